// File: rtl/complex_coef_apply_pkg.sv
// complex_coef_apply_pkg
//   Shared widths, the unity coefficient and sc16 field helpers for the
//   one-tap complex equaliser (complex_coef_apply).
//   sc16 layout: I in [31:16], Q in [15:0], both two's complement.
package complex_coef_apply_pkg;

  localparam int SC16_W      = 16;
  localparam int SC16_PAIR_W = 32;
  localparam int MUL_W       = 32;  // one 16x16 signed product
  localparam int PROD_W      = 33;  // sum/difference of two products, no overflow

  // 0x7FFF in Q1.15 is the closest representable value to 1.0 + 0j
  localparam logic [SC16_PAIR_W-1:0] UNITY_COEF = 32'h7FFF_0000;

  function automatic logic signed [SC16_W-1:0] sc16_i(input logic [SC16_PAIR_W-1:0] word);
    return $signed(word[SC16_PAIR_W-1:SC16_W]);
  endfunction

  function automatic logic signed [SC16_W-1:0] sc16_q(input logic [SC16_PAIR_W-1:0] word);
    return $signed(word[SC16_W-1:0]);
  endfunction

endpackage

// File: rtl/complex_coef_apply_round_sat.sv
// sc16_round_sat
//   Final stage of one lane: arithmetic shift right by SHIFT of a 33-bit value
//   that already carries the rounding offset, then saturation to 16 bits.
//   Ports:
//     din   in  33  rounded full-precision lane value (signed)
//     dout  out 16  saturated result
//     sat   out 1   result was clamped
module sc16_round_sat
  import complex_coef_apply_pkg::*;
#(
  parameter int SHIFT = 15
) (
  input  logic signed [PROD_W-1:0] din,
  output logic        [SC16_W-1:0] dout,
  output logic                     sat
);

  localparam logic signed [PROD_W-1:0] MAX_V = 33'sd32767;
  localparam logic signed [PROD_W-1:0] MIN_V = -33'sd32768;

  logic signed [PROD_W-1:0] shifted;

  assign shifted = din >>> SHIFT;

  // Clamp the shifted value into the sc16 range and flag when clamping occurs
  always_comb begin
    dout = shifted[SC16_W-1:0];
    sat  = 1'b0;
    if (shifted > MAX_V) begin
      dout = 16'h7FFF;
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      dout = 16'h8000;
      sat  = 1'b1;
    end else begin
      dout = shifted[SC16_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/complex_coef_apply.sv
// complex_coef_apply
//   One-tap complex equaliser: y = x * c on sc16 samples, with the coefficient
//   switched only at packet starts. 3-stage pipeline (multiply, add+round,
//   shift+saturate), 1 sample/cycle, 3-cycle latency.
//   Optional feature macro: COMPLEX_COEF_APPLY_SAT_CNT_EN adds the sat_count port.
//   Ports:
//     clk, reset, clear            clock, sync active-high reset, sync flush
//     c_tdata/c_tvalid/c_tready    coefficient stream (sc16)
//     i_tdata/i_tlast/i_tvalid/i_tready  sample stream in
//     o_tdata/o_tlast/o_tvalid/o_tready  product stream out
//     sat_count                    saturated output word count (macro only)
module complex_coef_apply
  import complex_coef_apply_pkg::*;
#(
  parameter int SHIFT = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [SC16_PAIR_W-1:0] c_tdata,
  input  logic                   c_tvalid,
  output logic                   c_tready,
  input  logic [SC16_PAIR_W-1:0] i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   i_tready,
  output logic [SC16_PAIR_W-1:0] o_tdata,
  output logic                   o_tlast,
  output logic                   o_tvalid,
  input  logic                   o_tready
`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
  ,
  output logic [15:0]            sat_count
`endif
);

  localparam logic signed [PROD_W-1:0] ROUND_ADD =
    $signed({{(PROD_W-1){1'b0}}, 1'b1} << (SHIFT - 1));

  logic flush;
  logic en;
  logic accept;
  logic [SC16_PAIR_W-1:0] active_coef;
  logic [SC16_PAIR_W-1:0] pend_coef;
  logic pend_vld;
  logic sof;
  logic [SC16_PAIR_W-1:0] coef_sel;
  logic signed [SC16_W-1:0] x_i, x_q, c_i, c_q;

  logic s1_vld, s1_last;
  logic signed [MUL_W-1:0] ac, bd, ad, bc;
  logic s2_vld, s2_last;
  logic signed [PROD_W-1:0] s2_i, s2_q;
  logic [SC16_W-1:0] res_i, res_q;
  logic sat_i, sat_q;

  assign flush    = reset | clear;
  assign en       = ~o_tvalid | o_tready;
  assign i_tready = en;
  assign accept   = i_tvalid & en;
  assign c_tready = ~pend_vld;

  // A packet's first sample picks up a pending coefficient in the same cycle it is swapped in
  assign coef_sel = (sof & pend_vld) ? pend_coef : active_coef;

  assign x_i = sc16_i(i_tdata);
  assign x_q = sc16_q(i_tdata);
  assign c_i = sc16_i(coef_sel);
  assign c_q = sc16_q(coef_sel);

  // Coefficient staging and packet-start tracking
  always_ff @(posedge clk) begin
    if (flush) begin
      active_coef <= UNITY_COEF;
      pend_coef   <= 32'h0000_0000;
      pend_vld    <= 1'b0;
      sof         <= 1'b1;
    end else begin
      // the two branches are exclusive: a coef can only land while nothing is pending
      if (c_tvalid & c_tready) begin
        pend_coef <= c_tdata;
        pend_vld  <= 1'b1;
      end else if (accept & sof & pend_vld) begin
        active_coef <= pend_coef;
        pend_vld    <= 1'b0;
      end
      if (accept) begin
        sof <= i_tlast;
      end
    end
  end

  // S1: four partial products
  always_ff @(posedge clk) begin
    if (flush) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      ac      <= 32'sd0;
      bd      <= 32'sd0;
      ad      <= 32'sd0;
      bc      <= 32'sd0;
    end else if (en) begin
      s1_vld  <= i_tvalid;
      s1_last <= i_tlast;
      ac      <= MUL_W'(x_i) * MUL_W'(c_i);
      bd      <= MUL_W'(x_q) * MUL_W'(c_q);
      ad      <= MUL_W'(x_i) * MUL_W'(c_q);
      bc      <= MUL_W'(x_q) * MUL_W'(c_i);
    end
  end

  // S2: complex combine plus half-LSB rounding offset
  always_ff @(posedge clk) begin
    if (flush) begin
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_i    <= 33'sd0;
      s2_q    <= 33'sd0;
    end else if (en) begin
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
      s2_i    <= PROD_W'(ac) - PROD_W'(bd) + ROUND_ADD;
      s2_q    <= PROD_W'(ad) + PROD_W'(bc) + ROUND_ADD;
    end
  end

  sc16_round_sat #(.SHIFT(SHIFT)) u_sat_i (.din(s2_i), .dout(res_i), .sat(sat_i));
  sc16_round_sat #(.SHIFT(SHIFT)) u_sat_q (.din(s2_q), .dout(res_q), .sat(sat_q));

  // S3: registered output word, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (flush) begin
      o_tvalid <= 1'b0;
      o_tdata  <= 32'h0000_0000;
      o_tlast  <= 1'b0;
    end else if (en) begin
      o_tvalid <= s2_vld;
      o_tdata  <= {res_i, res_q};
      o_tlast  <= s2_last;
    end
  end

`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
  logic out_sat;

  // Saturation flag travelling with the output word
  always_ff @(posedge clk) begin
    if (flush) begin
      out_sat <= 1'b0;
    end else if (en) begin
      out_sat <= sat_i | sat_q;
    end
  end

  // Sticky-at-max count of delivered words that clipped
  always_ff @(posedge clk) begin
    if (flush) begin
      sat_count <= 16'h0000;
    end else if (o_tvalid & o_tready & out_sat & (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  logic [1:0] unused_sat;
  assign unused_sat = {sat_i, sat_q};
`endif

endmodule

// File: tb/tb_complex_coef_apply.sv
// tb_complex_coef_apply
//   Self-checking bench for complex_coef_apply: directed scenarios plus a
//   randomized run against an integer reference model of y = x * c with
//   packet-boundary coefficient switching.
module tb_complex_coef_apply;

  localparam int SHIFT = 15;
  localparam logic [31:0] UNITY = 32'h7FFF_0000;

  logic clk;
  logic reset, clear;
  logic [31:0] c_tdata;
  logic c_tvalid, c_tready;
  logic [31:0] i_tdata;
  logic i_tlast, i_tvalid, i_tready;
  logic [31:0] o_tdata;
  logic o_tlast, o_tvalid, o_tready;
`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  complex_coef_apply #(.SHIFT(SHIFT)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .c_tdata(c_tdata), .c_tvalid(c_tvalid), .c_tready(c_tready),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [33:0] exp_q[$];   // {sat, tlast, I, Q}
  logic [31:0] coef_q[$];  // at most one coefficient waiting for a packet start
  logic [31:0] out_log[$];
  logic [31:0] m_active;
  bit m_sof;
  int m_sat;
  int cyc, acc_cyc, out_cyc, n_acc;
  bit stalled;
  logic [32:0] held;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // round half up to SHIFT fraction bits, then clamp to sc16
  function automatic void scale16(input longint v, output logic [15:0] r, output bit s);
    longint t;
    t = (v + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
    if (t > 32767) begin
      r = 16'h7FFF; s = 1'b1;
    end else if (t < -32768) begin
      r = 16'h8000; s = 1'b1;
    end else begin
      r = t[15:0]; s = 1'b0;
    end
  endfunction

  function automatic logic [33:0] ref_word(input logic [31:0] x, input logic [31:0] c, input logic last);
    longint a, b, cr, ci, re, im;
    logic [15:0] ri, rq;
    bit si, sq;
    a  = longint'($signed(x[31:16]));
    b  = longint'($signed(x[15:0]));
    cr = longint'($signed(c[31:16]));
    ci = longint'($signed(c[15:0]));
    re = a * cr - b * ci;
    im = a * ci + b * cr;
    scale16(re, ri, si);
    scale16(im, rq, sq);
    return {si | sq, last, ri, rq};
  endfunction

  // One clock cycle: drive at negedge, evaluate handshakes, check outputs, advance model
  task automatic step(input bit iv, input logic [31:0] idat, input bit il,
                      input bit cv, input logic [31:0] cdat, input bit ordy, input bit clr);
    bit acc_i, acc_c, pop;
    logic [33:0] e;
    @(negedge clk);
    i_tvalid = iv; i_tdata = idat; i_tlast = il;
    c_tvalid = cv; c_tdata = cdat;
    o_tready = ordy; clear = clr;
    #1;
    cyc++;
    if (stalled) begin
      check_eq("hold_valid", o_tvalid, 1);
      check_eq("hold_word", {o_tlast, o_tdata}, held);
    end
    check_eq("c_tready", c_tready, coef_q.size() == 0);
`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
    check_eq("sat_count", sat_count, m_sat);
`endif
    acc_i = iv && i_tready && !clr;
    acc_c = cv && c_tready && !clr;
    pop   = o_tvalid && ordy && !clr;
    if (pop) begin
      check_eq("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("out_word", {o_tlast, o_tdata}, e[32:0]);
        if (e[33]) m_sat++;
        out_log.push_back(o_tdata);
        out_cyc = cyc;
      end
    end
    if (acc_i) begin
      if (m_sof && coef_q.size() > 0) m_active = coef_q.pop_front();
      exp_q.push_back(ref_word(idat, m_active, il));
      m_sof = il;
      acc_cyc = cyc;
      n_acc++;
    end
    if (acc_c) coef_q.push_back(cdat);
    stalled = o_tvalid && !ordy && !clr;
    held = {o_tlast, o_tdata};
    if (clr) begin
      exp_q.delete(); coef_q.delete();
      m_active = UNITY; m_sof = 1'b1; m_sat = 0; stalled = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 32'h0, 0, 0, 32'h0, 1, 0);
  endtask

  initial begin
    int start, guard;
    m_active = UNITY; m_sof = 1'b1; m_sat = 0;
    cyc = 0; acc_cyc = 0; out_cyc = 0; n_acc = 0; stalled = 1'b0; held = 33'h0;
    reset = 1'b1; clear = 1'b0;
    c_tdata = 32'h0; c_tvalid = 1'b0;
    i_tdata = 32'h0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_o_tvalid", o_tvalid, 0);
    check_eq("rst_o_tdata", o_tdata, 0);
    check_eq("rst_o_tlast", o_tlast, 0);
    check_eq("rst_c_tready", c_tready, 1);
`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
    check_eq("rst_sat_count", sat_count, 0);
`endif

    // 1: unity coefficient passes the sample through, 3-cycle latency
    out_log.delete();
    step(1, 32'h03E8_F830, 1, 0, 32'h0, 1, 0);
    idle(5);
    check_eq("t1_count", out_log.size(), 1);
    if (out_log.size() > 0) check_eq("t1_word", out_log[0], 32'h03E8_F830);
    check_eq("t1_latency", out_cyc - acc_cyc, 3);

    // 2: coef 0.5j, mid-packet coef waits for the next packet
    out_log.delete();
    step(0, 32'h0, 0, 1, 32'h0000_4000, 1, 0);
    step(1, 32'h07D0_03E8, 0, 0, 32'h0, 1, 0);
    step(1, 32'h07D0_03E8, 0, 1, 32'h4000_0000, 1, 0);
    step(1, 32'h07D0_03E8, 1, 0, 32'h0, 1, 0);
    step(1, 32'h07D0_03E8, 1, 0, 32'h0, 1, 0);
    idle(5);
    check_eq("t2_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check_eq("t2_w0", out_log[0], 32'hFE0C_03E8);
      check_eq("t2_w2", out_log[2], 32'hFE0C_03E8);
      check_eq("t2_w3", out_log[3], 32'h03E8_01F4);
    end

    // 3: saturating products
    out_log.delete();
    step(0, 32'h0, 0, 1, 32'h7FFF_7FFF, 1, 0);
    step(1, 32'h7FFF_7FFF, 1, 0, 32'h0, 1, 0);
    step(0, 32'h0, 0, 1, 32'h8000_0000, 1, 0);
    step(1, 32'h8000_0000, 1, 0, 32'h0, 1, 0);
    idle(5);
    check_eq("t3_count", out_log.size(), 2);
    if (out_log.size() == 2) begin
      check_eq("t3_w0", out_log[0], 32'h0000_7FFF);
      check_eq("t3_w1", out_log[1], 32'h7FFF_0000);
    end
`ifdef COMPLEX_COEF_APPLY_SAT_CNT_EN
    check_eq("t3_sat_count", sat_count, 2);
`endif

    // 5: second coefficient blocked until a packet start consumes the first
    step(0, 32'h0, 0, 1, 32'h1234_5678, 1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 32'h0, 0, 1, 32'h0000_7FFF, 1, 0);
      check_eq("t5_blocked", c_tready, 0);
    end
    step(1, 32'h0100_0200, 1, 1, 32'h0000_7FFF, 1, 0);
    check_eq("t5_still_blocked", c_tready, 0);
    step(0, 32'h0, 0, 1, 32'h0000_7FFF, 1, 0);
    check_eq("t5_released", c_tready, 1);
    step(1, 32'h0100_0200, 1, 0, 32'h0, 1, 0);
    idle(5);

    // 6: clear with three samples in flight
    out_log.delete();
    step(0, 32'h0, 0, 1, 32'h0000_4000, 1, 0);
    step(1, 32'h1111_2222, 0, 0, 32'h0, 1, 0);
    step(1, 32'h3333_4444, 0, 1, 32'h4000_0000, 1, 0);
    step(1, 32'h5555_6666, 1, 0, 32'h0, 1, 0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(0, 32'h0, 0, 0, 32'h0, 1, 0);
      check_eq("t6_no_out", o_tvalid, 0);
    end
    check_eq("t6_c_tready", c_tready, 1);
    check_eq("t6_flushed", out_log.size(), 0);
    step(1, 32'h03E8_F830, 1, 0, 32'h0, 1, 0);
    idle(5);
    check_eq("t6_count", out_log.size(), 1);
    if (out_log.size() == 1) check_eq("t6_unity", out_log[0], 32'h03E8_F830);

    // 4: randomized traffic with back-pressure
    start = n_acc;
    guard = 0;
    while ((n_acc - start) < 1000 && guard < 20000) begin
      step($urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom(), $urandom_range(0, 1) == 1, 0);
      guard++;
    end
    check_eq("t4_samples", n_acc - start, 1000);
    idle(10);
    check_eq("t4_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
